bsg_nonsynth_dramsim3_trace_driver: RTL and testbench
=====================================================

# bsg_nonsynth_dramsim3_trace_driver

Multi-channel, self-checking trace driver for `bsg_nonsynth_dramsim3` test benches. It replaces the per-channel `bsg_fsb_node_trace_replay` wiring with one block that does four things per channel: fetches commands from a combinational test ROM, issues read/write requests, supplies address-derived write data, and checks returned read data. It sits between `num_channels_p` test ROMs and one dramsim3 instance, and reports aggregate done, error and mismatch status.

## Interface
- `num_channels_p`, 8, channels driven (one engine each)
- `ch_addr_width_p`, 32, channel address width
- `data_width_p`, 256, data word width; must be a multiple of 32
- `rom_addr_width_p`, 20, ROM address width
- `max_reads_p`, 8, outstanding reads allowed per channel (≥1)
- `seed_p`, 32'hA5A5_0000, data pattern seed
- `clk_i` in 1: clock
- `reset_n_i` in 1: reset, asynchronous active-low
- `rom_addr_o` out `[num_channels_p][rom_addr_width_p]`: ROM address per channel
- `rom_data_i` in `[num_channels_p][4+1+ch_addr_width_p]`: ROM word, laid out as `{opcode[3:0], write_not_read, ch_addr}`
- `v_o`, `write_not_read_o` out `[num_channels_p]`: request valid and request type
- `ch_addr_o` out `[num_channels_p][ch_addr_width_p]`: request address
- `yumi_i` in `[num_channels_p]`: request accepted
- `data_v_o` out `[num_channels_p]`: write data valid
- `data_o` out `[num_channels_p][data_width_p]`: write data
- `data_yumi_i` in `[num_channels_p]`: write data accepted
- `data_v_i` in `[num_channels_p]`: read data valid
- `data_i` in `[num_channels_p][data_width_p]`: read data
- `read_done_ch_addr_i` in `[num_channels_p][ch_addr_width_p]`: address of the returned read
- `check_en_i` in 1: enables read-data comparison
- `done_o` out 1: all channels finished, no reads outstanding
- `error_o` out 1: sticky OR of channel errors
- `mismatch_count_o` out 16: saturating total of read-data mismatches

## Operation
- Pattern function: pat(a) is the 32-bit word `{zero-extended a[31:0]} ^ seed_p`, replicated `data_width_p/32` times. Write data is pat(ch_addr). The expected read data is pat(read_done_ch_addr_i).
- Opcodes:
  - 1: REQ, a single read or write
  - 2: FENCE, wait until outstanding reads reach 0
  - 3: DELAY, wait `ch_addr[15:0]` cycles
  - 4: FINISH
  - any other value: error
- Per-channel FSM states: ISSUE, WDATA, FENCE, DELAY, DONE, ERROR. Reset state is ISSUE with `rom_addr_o = 0`.
- ISSUE decodes `rom_data_i[rom_addr_o]`:
  - REQ read: `v_o=1` only while outstanding < `max_reads_p`. On `yumi_i`: outstanding +1, rom_addr +1.
  - REQ write: `v_o=1`. On `yumi_i`: go to WDATA, rom_addr +1.
  - FENCE: rom_addr +1, go to FENCE.
  - DELAY: load a 16-bit counter, rom_addr +1, go to DELAY.
  - FINISH: go to DONE.
  - Other opcode: go to ERROR.
- WDATA: `data_v_o=1` with pat(latched addr). On `data_yumi_i` go to ISSUE.
- FENCE: go to ISSUE in the cycle after outstanding reads = 0.
- DELAY: decrement the counter each cycle. At 0, go to ISSUE. A count of 0 leaves DELAY after 1 cycle.
- DONE and ERROR are absorbing until reset. Read returns are still accepted and checked in these states.
- Read return (`data_v_i`):
  - outstanding −1.
  - If `check_en_i` is set and the data differs from expected, `mismatch_count_o` +1, saturating at 16'hFFFF.
  - A return with outstanding = 0 sets the channel error and leaves the counter at 0.
- When several channels mismatch in the same cycle, the count adds the population count, then saturates.
- `done_o` = every channel in DONE and all outstanding counts = 0. `error_o` = any channel in ERROR or with a flagged return.

## Timing
- Reset values: `v_o=0`, `data_v_o=0`, `rom_addr_o=0`, `done_o=0`, `error_o=0`, `mismatch_count_o=0`, outstanding counts = 0.
- Asserting reset mid-run clears all state immediately. Releasing it starts fetching from address 0.
- ROM is combinational. A REQ asserts `v_o` in the same cycle its ROM word is addressed, giving 0-cycle issue latency.
- Back-to-back REQ accepts give one request per cycle.
- A write costs at least 2 cycles: the request cycle, then the data cycle.
- Read issue and return in the same cycle net the outstanding count to 0 change. A full counter with a simultaneous return does not permit issue in that cycle; issue resumes in the next cycle.
- `v_o` and `data_v_o` are never both 1 on the same channel.
- `done_o` and `error_o` are registered: they rise 1 cycle after their condition.

## Structure
- Package `bsg_nonsynth_dramsim3_trace_driver_pkg` holds:
  - the opcode enum
  - the channel FSM state enum
  - the packed ROM-word struct typedef
- Sub-module `bsg_nonsynth_dramsim3_trace_channel` is one engine containing the FSM, outstanding counter, delay counter and pattern check. It outputs a per-cycle mismatch bit.
- The top generates `num_channels_p` engines and performs the done/error reduction and the saturating popcount accumulator.

## Test plan
- Ch0 ROM has write 0x40, read 0x40, FINISH. Dramsim3 model returns correct data. Required: `data_o` = pat(0x40); mismatch 0; `done_o` rises.
- `max_reads_p=2`, 4 reads, returns withheld. Required: exactly 2 accepts, then `v_o` stays 0 until a return; total 4 issued.
- Return corrupted data on 3 reads with `check_en_i=1`. Required: `mismatch_count_o=3`. Same run with `check_en_i=0`: required count 0.
- Sequence read, FENCE, write, with the read return delayed 50 cycles. Required: write `v_o` not before 1 cycle after the return.
- DELAY 10, then REQ. Required: `v_o` asserts exactly 11 cycles after DELAY is addressed.
- Opcode 4'hF, or a spurious `data_v_i`. Required: `error_o=1` next cycle. Reset asserted mid-run: all outputs 0 immediately, refetch from 0.

Source files
------------

// File: rtl/bsg_nonsynth_dramsim3_trace_driver_pkg.sv
// Shared types and helpers for the dramsim3 trace driver: opcodes, channel
// FSM states, the ROM word header layout and the address-derived data pattern.
package bsg_nonsynth_dramsim3_trace_driver_pkg;

    localparam int unsigned opcode_width   = 4;
    localparam int unsigned pat_width      = 32;
    localparam int unsigned delay_width    = 16;
    localparam int unsigned mismatch_width = 16;

    typedef enum logic [opcode_width-1:0] {
        OP_REQ    = 4'd1,
        OP_FENCE  = 4'd2,
        OP_DELAY  = 4'd3,
        OP_FINISH = 4'd4
    } opcode_e;

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WDATA = 3'd1,
        S_FENCE = 3'd2,
        S_DELAY = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } chan_state_e;

    // Upper bits of a ROM word; the channel address fills the bits below.
    typedef struct packed {
        logic [opcode_width-1:0] opcode;
        logic                    write_not_read;
    } rom_word_s;

    localparam int unsigned rom_hdr_width = $bits(rom_word_s);

    function automatic logic [pat_width-1:0] pat_word(input logic [pat_width-1:0] addr,
                                                      input logic [pat_width-1:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/bsg_nonsynth_dramsim3_trace_channel.sv
// One trace engine: fetches ROM commands, issues requests, supplies write
// data, tracks outstanding reads and checks returned read data.
module bsg_nonsynth_dramsim3_trace_channel
    import bsg_nonsynth_dramsim3_trace_driver_pkg::*;
#(
    parameter int unsigned ch_addr_width_p  = 32,
    parameter int unsigned data_width_p     = 256,
    parameter int unsigned rom_addr_width_p = 20,
    parameter int unsigned max_reads_p      = 8,
    parameter logic [31:0] seed_p           = 32'hA5A5_0000
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    output logic [rom_addr_width_p-1:0]              rom_addr,
    input  logic [rom_hdr_width+ch_addr_width_p-1:0] rom_data,
    output logic                                     v_c,
    output logic                                     write_not_read_c,
    output logic [ch_addr_width_p-1:0]               ch_addr_c,
    input  logic                                     yumi,
    output logic                                     data_v_c,
    output logic [data_width_p-1:0]                  data,
    input  logic                                     data_yumi,
    input  logic                                     ret_v,
    input  logic [data_width_p-1:0]                  ret_data,
    input  logic [ch_addr_width_p-1:0]               ret_ch_addr,
    input  logic                                     check_en,
    output logic                                     mismatch_c,
    output logic                                     error_c,
    output logic                                     done_c
);

    localparam int unsigned cnt_width = $clog2(max_reads_p + 1);
    localparam int unsigned repl      = data_width_p / pat_width;
    localparam int unsigned rom_width = rom_hdr_width + ch_addr_width_p;

    chan_state_e                 state_q, state_d;
    logic [rom_addr_width_p-1:0] rom_addr_q, rom_addr_d, rom_addr_inc;
    logic [cnt_width-1:0]        outst_q, outst_d;
    logic [delay_width-1:0]      delay_q, delay_d;
    logic [data_width_p-1:0]     data_q, data_d;
    logic                        err_q;
    rom_word_s                   word;
    logic [ch_addr_width_p-1:0]  req_addr;
    logic                        issue_rd, bad_op, spurious, ret_ok, rd_room;

    function automatic logic [data_width_p-1:0] pat(input logic [ch_addr_width_p-1:0] a);
        return {repl{pat_word(pat_width'(a), seed_p)}};
    endfunction

    assign word             = rom_word_s'(rom_data[rom_width-1 -: rom_hdr_width]);
    assign req_addr         = rom_data[ch_addr_width_p-1:0];
    assign rom_addr_inc     = rom_addr_q + rom_addr_width_p'(1);
    assign rd_room          = outst_q < cnt_width'(max_reads_p);
    assign write_not_read_c = word.write_not_read;
    assign ch_addr_c        = req_addr;
    assign rom_addr         = rom_addr_q;
    assign data             = data_q;

    // A return with nothing outstanding is flagged and never decrements.
    assign spurious = ret_v && (outst_q == '0);
    assign ret_ok   = ret_v && !spurious;

    assign mismatch_c = ret_v && check_en && (ret_data != pat(ret_ch_addr));
    assign error_c    = err_q || spurious || bad_op || (state_q == S_ERROR);
    assign done_c     = (state_q == S_DONE) && (outst_q == '0);

    // Next-state, request outputs and outstanding-read bookkeeping.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        delay_d    = delay_q;
        data_d     = data_q;
        outst_d    = outst_q;
        v_c        = 1'b0;
        data_v_c   = 1'b0;
        issue_rd   = 1'b0;
        bad_op     = 1'b0;

        case (state_q)
            S_ISSUE: begin
                case (word.opcode)
                    OP_REQ: begin
                        if (word.write_not_read) begin
                            v_c = rst_n;
                            if (yumi && v_c) begin
                                data_d     = pat(req_addr);
                                rom_addr_d = rom_addr_inc;
                                state_d    = S_WDATA;
                            end
                        end else begin
                            v_c = rst_n && rd_room;
                            if (yumi && v_c) begin
                                issue_rd   = 1'b1;
                                rom_addr_d = rom_addr_inc;
                            end
                        end
                    end
                    OP_FENCE: begin
                        rom_addr_d = rom_addr_inc;
                        state_d    = S_FENCE;
                    end
                    OP_DELAY: begin
                        delay_d    = req_addr[delay_width-1:0];
                        rom_addr_d = rom_addr_inc;
                        state_d    = S_DELAY;
                    end
                    OP_FINISH: state_d = S_DONE;
                    default: begin
                        bad_op  = 1'b1;
                        state_d = S_ERROR;
                    end
                endcase
            end
            S_WDATA: begin
                data_v_c = 1'b1;
                if (data_yumi) state_d = S_ISSUE;
            end
            S_FENCE: begin
                if (outst_q == '0) state_d = S_ISSUE;
            end
            S_DELAY: begin
                // Counts of 0 and 1 both leave after a single cycle here.
                if (delay_q <= delay_width'(1)) state_d = S_ISSUE;
                if (delay_q != '0) delay_d = delay_q - delay_width'(1);
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        case ({issue_rd, ret_ok})
            2'b10:   outst_d = outst_q + cnt_width'(1);
            2'b01:   outst_d = outst_q - cnt_width'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ISSUE;
            rom_addr_q <= '0;
            outst_q    <= '0;
            delay_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            outst_q    <= outst_d;
            delay_q    <= delay_d;
            data_q     <= data_d;
            err_q      <= err_q || spurious;
        end
    end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_trace_driver.sv
// Multi-channel trace driver: one engine per channel plus aggregate done,
// error and saturating mismatch-count status.
module bsg_nonsynth_dramsim3_trace_driver
    import bsg_nonsynth_dramsim3_trace_driver_pkg::*;
#(
    parameter int unsigned num_channels_p   = 8,
    parameter int unsigned ch_addr_width_p  = 32,
    parameter int unsigned data_width_p     = 256,
    parameter int unsigned rom_addr_width_p = 20,
    parameter int unsigned max_reads_p      = 8,
    parameter logic [31:0] seed_p           = 32'hA5A5_0000
) (
    input  logic                                                         clk_i,
    input  logic                                                         reset_n_i,
    output logic [num_channels_p-1:0][rom_addr_width_p-1:0]              rom_addr_o,
    input  logic [num_channels_p-1:0][rom_hdr_width+ch_addr_width_p-1:0] rom_data_i,
    output logic [num_channels_p-1:0]                                    v_o,
    output logic [num_channels_p-1:0]                                    write_not_read_o,
    output logic [num_channels_p-1:0][ch_addr_width_p-1:0]               ch_addr_o,
    input  logic [num_channels_p-1:0]                                    yumi_i,
    output logic [num_channels_p-1:0]                                    data_v_o,
    output logic [num_channels_p-1:0][data_width_p-1:0]                  data_o,
    input  logic [num_channels_p-1:0]                                    data_yumi_i,
    input  logic [num_channels_p-1:0]                                    data_v_i,
    input  logic [num_channels_p-1:0][data_width_p-1:0]                  data_i,
    input  logic [num_channels_p-1:0][ch_addr_width_p-1:0]               read_done_ch_addr_i,
    input  logic                                                         check_en_i,
    output logic                                                         done_o,
    output logic                                                         error_o,
    output logic [mismatch_width-1:0]                                    mismatch_count_o
);

    localparam int unsigned pop_width = $clog2(num_channels_p + 1);

    logic [num_channels_p-1:0] mismatch, ch_error, ch_done;
    logic [pop_width-1:0]      pop;
    logic [mismatch_width:0]   sum;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        bsg_nonsynth_dramsim3_trace_channel #(
            .ch_addr_width_p (ch_addr_width_p),
            .data_width_p    (data_width_p),
            .rom_addr_width_p(rom_addr_width_p),
            .max_reads_p     (max_reads_p),
            .seed_p          (seed_p)
        ) u_ch (
            .clk             (clk_i),
            .rst_n           (reset_n_i),
            .rom_addr        (rom_addr_o[c]),
            .rom_data        (rom_data_i[c]),
            .v_c             (v_o[c]),
            .write_not_read_c(write_not_read_o[c]),
            .ch_addr_c       (ch_addr_o[c]),
            .yumi            (yumi_i[c]),
            .data_v_c        (data_v_o[c]),
            .data            (data_o[c]),
            .data_yumi       (data_yumi_i[c]),
            .ret_v           (data_v_i[c]),
            .ret_data        (data_i[c]),
            .ret_ch_addr     (read_done_ch_addr_i[c]),
            .check_en        (check_en_i),
            .mismatch_c      (mismatch[c]),
            .error_c         (ch_error[c]),
            .done_c          (ch_done[c])
        );
    end

    // Same-cycle mismatches across channels add as a population count.
    always_comb begin
        pop = '0;
        for (int unsigned c = 0; c < num_channels_p; c++) begin
            pop = pop + pop_width'(mismatch[c]);
        end
        sum = (mismatch_width + 1)'(mismatch_count_o) + (mismatch_width + 1)'(pop);
    end

    // Aggregate status registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_o           <= 1'b0;
            error_o          <= 1'b0;
            mismatch_count_o <= '0;
        end else begin
            done_o           <= &ch_done;
            error_o          <= |ch_error;
            mismatch_count_o <= sum[mismatch_width] ? '1 : sum[mismatch_width-1:0];
        end
    end

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_trace_driver.sv
// Directed bench for the trace driver with a request/write-data scoreboard.
module tb_bsg_nonsynth_dramsim3_trace_driver;

    localparam int unsigned nc   = 2;
    localparam int unsigned aw   = 32;
    localparam int unsigned dw   = 64;
    localparam int unsigned raw  = 8;
    localparam int unsigned mr   = 2;
    localparam int unsigned rw   = 4 + 1 + aw;
    localparam logic [31:0] seed = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n;
    logic [nc-1:0][raw-1:0]   rom_addr;
    logic [nc-1:0][rw-1:0]    rom_data;
    logic [nc-1:0]            v, wnr, yumi, data_v, data_yumi, ret_v;
    logic [nc-1:0][aw-1:0]    ch_addr, ret_addr;
    logic [nc-1:0][dw-1:0]    wdata, ret_data;
    logic                     check_en, done, error;
    logic [15:0]              mc;
    logic                     req_en, wd_en;
    logic [rw-1:0]            rom [nc][256];

    logic [aw:0]              rq [nc][$];
    logic [dw-1:0]            wq [nc][$];
    int                       acc [nc];
    int                       n_cmp = 0;
    int                       n_bad = 0;
    logic [aw:0]              mon_req;
    logic [dw-1:0]            mon_dat;

    bsg_nonsynth_dramsim3_trace_driver #(
        .num_channels_p  (nc),
        .ch_addr_width_p (aw),
        .data_width_p    (dw),
        .rom_addr_width_p(raw),
        .max_reads_p     (mr),
        .seed_p          (seed)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .rom_addr_o         (rom_addr),
        .rom_data_i         (rom_data),
        .v_o                (v),
        .write_not_read_o   (wnr),
        .ch_addr_o          (ch_addr),
        .yumi_i             (yumi),
        .data_v_o           (data_v),
        .data_o             (wdata),
        .data_yumi_i        (data_yumi),
        .data_v_i           (ret_v),
        .data_i             (ret_data),
        .read_done_ch_addr_i(ret_addr),
        .check_en_i         (check_en),
        .done_o             (done),
        .error_o            (error),
        .mismatch_count_o   (mc)
    );

    assign yumi      = v & {nc{req_en}};
    assign data_yumi = data_v & {nc{wd_en}};

    always_comb begin
        for (int c = 0; c < nc; c++) rom_data[c] = rom[c][rom_addr[c]];
    end

    function automatic logic [dw-1:0] pat(input logic [31:0] a);
        logic [31:0] x;
        x = a ^ seed;
        return {x, x};
    endfunction

    function automatic logic [rw-1:0] w(input logic [3:0] op, input logic wr, input logic [31:0] a);
        return {op, wr, a};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_reset();
        tick();
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < nc; c++) begin
            acc[c] = 0;
            for (int a = 0; a < 256; a++) rom[c][a] = w(4'd4, 1'b0, 32'd0);
        end
    endtask

    task automatic release_reset();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic ret_set(input logic [nc-1:0] mask, input logic [31:0] a, input logic bad);
        for (int c = 0; c < nc; c++) begin
            ret_v[c]    = mask[c];
            ret_addr[c] = a;
            ret_data[c] = pat(a) ^ (bad ? 64'h1 : 64'h0);
        end
    endtask

    task automatic ret(input logic [nc-1:0] mask, input logic [31:0] a, input logic bad);
        ret_set(mask, a, bad);
        tick();
        ret_v = '0;
    endtask

    task automatic push_req(input int c, input logic wr, input logic [31:0] a);
        rq[c].push_back({wr, a});
    endtask

    // Monitor: pops expected requests / write data whenever a handshake fires.
    always @(negedge clk) begin
        for (int c = 0; c < nc; c++) begin
            if (reset_n && v[c] && data_v[c]) cmp("v_and_data_v", 64'(1), 64'(0));
            if (reset_n && v[c] && yumi[c]) begin
                acc[c]++;
                if (rq[c].size() == 0) cmp("req_unexpected", 64'({wnr[c], ch_addr[c]}), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    mon_req = rq[c].pop_front();
                    cmp("req", 64'({wnr[c], ch_addr[c]}), 64'(mon_req));
                end
            end
            if (reset_n && data_v[c] && data_yumi[c]) begin
                if (wq[c].size() == 0) cmp("wdata_unexpected", wdata[c], 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    mon_dat = wq[c].pop_front();
                    cmp("wdata", wdata[c], mon_dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first;
        int dly [3];
        int dexp [3];
        reset_n  = 1'b0;
        ret_v    = '0;
        ret_addr = '0;
        ret_data = '0;
        req_en   = 1'b1;
        wd_en    = 1'b1;
        check_en = 1'b1;

        // Write 0x40, read 0x40, finish; reset values checked while held.
        hold_reset();
        rom[0][0] = w(4'd1, 1'b1, 32'h40);
        rom[0][1] = w(4'd1, 1'b0, 32'h40);
        push_req(0, 1'b1, 32'h40);
        push_req(0, 1'b0, 32'h40);
        wq[0].push_back(pat(32'h40));
        #1;
        cmp("rst_v", 64'(v[0]), 64'(0));
        cmp("rst_data_v", 64'(data_v), 64'(0));
        cmp("rst_rom_addr", 64'(rom_addr[0]), 64'(0));
        cmp("rst_done", 64'(done), 64'(0));
        cmp("rst_error", 64'(error), 64'(0));
        cmp("rst_mc", 64'(mc), 64'(0));
        release_reset();
        cycles(6);
        cmp("done_waits_read", 64'(done), 64'(0));
        ret(2'b01, 32'h40, 1'b0);
        tick();
        cmp("basic_done", 64'(done), 64'(1));
        cmp("basic_mc", 64'(mc), 64'(0));
        cmp("basic_error", 64'(error), 64'(0));

        // Outstanding limit of 2 with returns withheld.
        hold_reset();
        for (int i = 0; i < 4; i++) begin
            rom[0][i] = w(4'd1, 1'b0, 32'h100 + 32'(i));
            push_req(0, 1'b0, 32'h100 + 32'(i));
        end
        release_reset();
        cycles(6);
        #1;
        cmp("maxrd_accepts", 64'(acc[0]), 64'(2));
        cmp("maxrd_stall", 64'(v[0]), 64'(0));
        ret_set(2'b01, 32'h100, 1'b0);
        #1;
        cmp("full_ret_no_issue", 64'(v[0]), 64'(0));
        tick();
        ret_v = '0;
        #1;
        cmp("issue_resumes", 64'(v[0]), 64'(1));
        tick();
        ret(2'b01, 32'h101, 1'b0);
        cycles(3);
        cmp("maxrd_total", 64'(acc[0]), 64'(4));
        cmp("maxrd_rom_addr", 64'(rom_addr[0]), 64'(4));
        ret(2'b01, 32'h102, 1'b0);
        ret(2'b01, 32'h103, 1'b0);
        tick();
        cmp("maxrd_done", 64'(done), 64'(1));

        // Three corrupted returns, checked then unchecked.
        for (int pass = 0; pass < 2; pass++) begin
            hold_reset();
            check_en = (pass == 0);
            for (int i = 0; i < 3; i++) begin
                rom[0][i] = w(4'd1, 1'b0, 32'h20 + 32'(4 * i));
                push_req(0, 1'b0, 32'h20 + 32'(4 * i));
            end
            release_reset();
            cycles(3);
            ret(2'b01, 32'h20, 1'b1);
            cycles(2);
            ret(2'b01, 32'h24, 1'b1);
            ret(2'b01, 32'h28, 1'b1);
            #1;
            cmp(pass == 0 ? "mm_checked" : "mm_unchecked", 64'(mc), pass == 0 ? 64'(3) : 64'(0));
            tick();
            cmp("mm_done", 64'(done), 64'(1));
        end
        check_en = 1'b1;

        // Mid-run reset with counters non-zero, then refetch from 0.
        hold_reset();
        rom[0][0] = w(4'd1, 1'b0, 32'h600);
        rom[0][1] = w(4'd1, 1'b0, 32'h604);
        push_req(0, 1'b0, 32'h600);
        push_req(0, 1'b0, 32'h604);
        release_reset();
        cycles(3);
        ret(2'b01, 32'h600, 1'b1);
        #1;
        cmp("pre_rst_mc", 64'(mc), 64'(1));
        cmp("pre_rst_rom_addr", 64'(rom_addr[0]), 64'(2));
        reset_n = 1'b0;
        #1;
        cmp("midrst_mc", 64'(mc), 64'(0));
        cmp("midrst_rom_addr", 64'(rom_addr[0]), 64'(0));
        cmp("midrst_v", 64'(v), 64'(0));
        push_req(0, 1'b0, 32'h600);
        push_req(0, 1'b0, 32'h604);
        release_reset();
        cycles(3);
        ret(2'b01, 32'h600, 1'b0);
        ret(2'b01, 32'h604, 1'b0);
        tick();
        cmp("refetch_done", 64'(done), 64'(1));
        cmp("refetch_mc", 64'(mc), 64'(0));

        // Both channels mismatch in the same cycle.
        hold_reset();
        for (int c = 0; c < nc; c++) begin
            rom[c][0] = w(4'd1, 1'b0, 32'h30);
            push_req(c, 1'b0, 32'h30);
        end
        release_reset();
        cycles(3);
        ret(2'b11, 32'h30, 1'b1);
        #1;
        cmp("mm_popcount", 64'(mc), 64'(2));
        tick();
        cmp("pop_done", 64'(done), 64'(1));

        // Read, FENCE, write with the return held back 50 cycles.
        hold_reset();
        rom[0][0] = w(4'd1, 1'b0, 32'h200);
        rom[0][1] = w(4'd2, 1'b0, 32'h0);
        rom[0][2] = w(4'd1, 1'b1, 32'h300);
        push_req(0, 1'b0, 32'h200);
        push_req(0, 1'b1, 32'h300);
        wq[0].push_back(pat(32'h300));
        release_reset();
        cnt = 0;
        repeat (50) begin
            #1;
            if (v[0]) cnt++;
            tick();
        end
        cmp("fence_hold", 64'(cnt), 64'(1));
        ret_set(2'b01, 32'h200, 1'b0);
        #1;
        cmp("fence_ret_cycle", 64'(v[0]), 64'(0));
        tick();
        ret_v = '0;
        #1;
        cmp("fence_after_ret", 64'(v[0]), 64'(0));
        tick();
        #1;
        cmp("fence_write_v", 64'(v[0]), 64'(1));
        cmp("fence_write_wnr", 64'(wnr[0]), 64'(1));
        cycles(5);
        cmp("fence_done", 64'(done), 64'(1));

        // DELAY N then REQ: v_o first rises N+1 cycles after (0 -> 2).
        dly[0] = 10; dexp[0] = 11;
        dly[1] = 0;  dexp[1] = 2;
        dly[2] = 3;  dexp[2] = 4;
        for (int t = 0; t < 3; t++) begin
            hold_reset();
            rom[0][0] = w(4'd3, 1'b0, 32'(dly[t]));
            rom[0][1] = w(4'd1, 1'b0, 32'h500);
            push_req(0, 1'b0, 32'h500);
            release_reset();
            first = -1;
            for (int k = 0; k < 21; k++) begin
                #1;
                if (v[0] && first < 0) first = k;
                tick();
            end
            cmp("delay_latency", 64'(first), 64'(dexp[t]));
            ret(2'b01, 32'h500, 1'b0);
            cycles(2);
            cmp("delay_done", 64'(done), 64'(1));
        end

        // Illegal opcode 4'hF.
        hold_reset();
        rom[0][0] = w(4'hF, 1'b0, 32'h0);
        release_reset();
        #1;
        cmp("badop_c0", 64'(error), 64'(0));
        tick();
        cmp("badop_c1", 64'(error), 64'(1));
        cmp("badop_v", 64'(v[0]), 64'(0));
        cycles(3);
        cmp("badop_sticky", 64'(error), 64'(1));

        // Spurious read return with nothing outstanding.
        hold_reset();
        release_reset();
        cycles(2);
        cmp("spur_before", 64'(error), 64'(0));
        ret(2'b01, 32'h77, 1'b0);
        cmp("spur_error", 64'(error), 64'(1));
        cmp("spur_mc", 64'(mc), 64'(0));
        cycles(2);
        cmp("spur_sticky", 64'(error), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        cmp("rst_clears_error", 64'(error), 64'(0));
        cmp("rst_clears_done", 64'(done), 64'(0));

        for (int c = 0; c < nc; c++) begin
            cmp("req_queue_empty", 64'(rq[c].size()), 64'(0));
            cmp("wdata_queue_empty", 64'(wq[c].size()), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
